// File: rtl/myadder1_arb_pkg.sv
// Shared types and helpers for the myadder1 stream arbiter.
//   arb_state_t : arbiter FSM states
//   LP_MAX_REQ  : largest supported requester count
//   f_idw(n)    : requester-index width, max(1, clog2(n))
package myadder1_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int unsigned LP_MAX_REQ = 4;

  function automatic int unsigned f_idw(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/myadder1_axis_skid.sv
// Two-entry AXI4-Stream skid buffer with registered ready.
//   i_clk, i_rst                 : clock, synchronous active-high reset
//   i_valid / o_ready / i_data   : upstream side
//   o_valid / i_ready / o_data   : downstream side (payload held while stalled)
module myadder1_axis_skid #(
  parameter int unsigned C_WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [C_WIDTH-1:0] i_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [C_WIDTH-1:0] o_data
);

  logic               r_out_valid;
  logic               r_skid_valid;
  logic [C_WIDTH-1:0] r_out_data;
  logic [C_WIDTH-1:0] r_skid_data;
  logic               w_in_fire;

  // Ready depends only on the skid register, so it never combinationally
  // follows i_ready.
  assign o_ready   = ~r_skid_valid;
  assign w_in_fire = i_valid & ~r_skid_valid;
  assign o_valid   = r_out_valid;
  assign o_data    = r_out_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_out_data   <= '0;
      r_skid_data  <= '0;
    end else if (!r_out_valid || i_ready) begin
      // Output slot frees up: drain the skid entry first, else take input.
      if (r_skid_valid) begin
        r_out_data   <= r_skid_data;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        r_out_valid <= w_in_fire;
        if (w_in_fire) r_out_data <= i_data;
      end
    end else if (w_in_fire) begin
      r_skid_data  <= i_data;
      r_skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/myadder1_stream_arbiter.sv
// Packet-granular round-robin arbiter in front of the vadd s_axis port.
//   ap_clk, areset       : clock, synchronous active-high reset
//   ctrl_enable          : allows new grants (packets in flight always finish)
//   s_axis_*             : C_NUM_REQ packed input streams
//   m_axis_*             : merged output stream, m_axis_tid = requester index
//   busy                 : 1 while a packet is locked
//   stat_pkt_count       : packed per-requester completed-packet counters
module myadder1_stream_arbiter
  import myadder1_arb_pkg::*;
#(
  parameter int unsigned C_NUM_REQ     = 2,
  parameter int unsigned C_TDATA_WIDTH = 512,
  parameter int unsigned C_CNT_WIDTH   = 32,
  localparam int unsigned IDW          = f_idw(C_NUM_REQ)
) (
  input  logic                               ap_clk,
  input  logic                               areset,
  input  logic                               ctrl_enable,
  input  logic [C_NUM_REQ-1:0]               s_axis_tvalid,
  output logic [C_NUM_REQ-1:0]               s_axis_tready,
  input  logic [C_NUM_REQ*C_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [C_NUM_REQ*C_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [C_NUM_REQ-1:0]               s_axis_tlast,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic [C_TDATA_WIDTH-1:0]           m_axis_tdata,
  output logic [C_TDATA_WIDTH/8-1:0]         m_axis_tkeep,
  output logic                               m_axis_tlast,
  output logic [IDW-1:0]                     m_axis_tid,
  output logic                               busy,
  output logic [C_NUM_REQ*C_CNT_WIDTH-1:0]   stat_pkt_count
);

  localparam int unsigned KW = C_TDATA_WIDTH / 8;
  localparam int unsigned PW = C_TDATA_WIDTH + KW + 1 + IDW;

  arb_state_t                              r_state;
  logic [IDW-1:0]                          r_grant;
  logic [IDW-1:0]                          r_last_grant;
  logic [C_NUM_REQ-1:0][C_CNT_WIDTH-1:0]   r_cnt;

  logic           w_sel_valid;
  logic           w_sel_last;
  logic           w_skid_ready;
  logic           w_accept;
  logic [IDW-1:0] w_pick;
  logic [PW-1:0]  w_skid_in;
  logic [PW-1:0]  w_skid_out;

  // First requesting index after i_last, wrapping modulo C_NUM_REQ.
  function automatic logic [IDW-1:0] f_rr_pick(input logic [C_NUM_REQ-1:0] i_req,
                                               input logic [IDW-1:0]       i_last);
    logic [IDW-1:0] pick;
    logic           found;
    int unsigned    idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= C_NUM_REQ; k++) begin
      idx = (32'(i_last) + k) % C_NUM_REQ;
      if (!found && i_req[idx]) begin
        pick  = idx[IDW-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign w_pick      = f_rr_pick(s_axis_tvalid, r_last_grant);
  assign w_sel_valid = (r_state == LOCKED) && s_axis_tvalid[r_grant];
  assign w_sel_last  = s_axis_tlast[r_grant];
  assign w_accept    = w_sel_valid && w_skid_ready;
  assign busy        = (r_state == LOCKED);
  assign stat_pkt_count = r_cnt;

  assign w_skid_in = {s_axis_tdata[r_grant*C_TDATA_WIDTH +: C_TDATA_WIDTH],
                      s_axis_tkeep[r_grant*KW +: KW],
                      w_sel_last,
                      r_grant};

  always_comb begin
    s_axis_tready = '0;
    if (r_state == LOCKED) s_axis_tready[r_grant] = w_skid_ready;
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_last_grant <= IDW'(C_NUM_REQ - 1);
      r_cnt        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ctrl_enable && (|s_axis_tvalid)) begin
            r_grant <= w_pick;
            r_state <= LOCKED;
          end
        end
        LOCKED: begin
          if (w_accept && w_sel_last) begin
            r_last_grant   <= r_grant;
            r_cnt[r_grant] <= r_cnt[r_grant] + 1'b1;
            r_state        <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  myadder1_axis_skid #(
    .C_WIDTH(PW)
  ) u_skid (
    .i_clk  (ap_clk),
    .i_rst  (areset),
    .i_valid(w_sel_valid),
    .o_ready(w_skid_ready),
    .i_data (w_skid_in),
    .o_valid(m_axis_tvalid),
    .i_ready(m_axis_tready),
    .o_data (w_skid_out)
  );

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid} = w_skid_out;

endmodule

// File: tb/tb_myadder1_stream_arbiter.sv
// Self-checking bench for myadder1_stream_arbiter (2 requesters, 16-bit data,
// 4-bit counters so that counter wrap is reachable).
module tb_myadder1_stream_arbiter;

  localparam int NREQ = 2;
  localparam int W    = 16;
  localparam int KW   = W / 8;
  localparam int CW   = 4;
  localparam int IDW  = 1;
  localparam int PW   = W + KW + 1 + IDW;

  typedef struct {
    logic [W-1:0]  data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  typedef struct {
    logic [W-1:0]   data;
    logic [KW-1:0]  keep;
    logic           last;
    logic [IDW-1:0] tid;
    int             cyc;
  } obs_t;

  logic                 clk = 1'b0;
  logic                 areset = 1'b1;
  logic                 ctrl_enable = 1'b1;
  logic [NREQ-1:0]      s_tvalid;
  logic [NREQ-1:0]      s_tready;
  logic [NREQ*W-1:0]    s_tdata;
  logic [NREQ*KW-1:0]   s_tkeep;
  logic [NREQ-1:0]      s_tlast;
  logic                 m_tvalid;
  logic                 m_tready;
  logic [W-1:0]         m_tdata;
  logic [KW-1:0]        m_tkeep;
  logic                 m_tlast;
  logic [IDW-1:0]       m_tid;
  logic                 busy;
  logic [NREQ*CW-1:0]   stat;

  always #5 clk = ~clk;

  myadder1_stream_arbiter #(
    .C_NUM_REQ    (NREQ),
    .C_TDATA_WIDTH(W),
    .C_CNT_WIDTH  (CW)
  ) dut (
    .ap_clk        (clk),
    .areset        (areset),
    .ctrl_enable   (ctrl_enable),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tlast  (s_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tlast  (m_tlast),
    .m_axis_tid    (m_tid),
    .busy          (busy),
    .stat_pkt_count(stat)
  );

  beat_t         src_q[NREQ][$];
  beat_t         exp_src[NREQ][$];
  obs_t          obs_q[$];
  obs_t          exp_q[$];
  bit            src_en[NREQ];
  int            acc_cnt[NREQ];
  int            first_cyc[NREQ];
  bit            bp_mode;
  int            cyc;
  int            n_cmp;
  int            n_fail;
  int            stall_viol;
  bit            prev_stall;
  logic [PW-1:0] prev_pl;

  function automatic logic [PW-1:0] pack_o(obs_t o);
    return {o.data, o.keep, o.last, o.tid};
  endfunction

  function automatic int cnt(int r);
    return int'(stat[r*CW +: CW]);
  endfunction

  // One clock: observe at the falling edge, drive 1 time unit after rising.
  task automatic tick();
    bit fire[NREQ];
    @(negedge clk);
    if (prev_stall && (!m_tvalid || {m_tdata, m_tkeep, m_tlast, m_tid} !== prev_pl))
      stall_viol++;
    prev_stall = m_tvalid && !m_tready && !areset;
    prev_pl    = {m_tdata, m_tkeep, m_tlast, m_tid};
    if (m_tvalid && m_tready && !areset) begin
      obs_t o;
      o.data = m_tdata; o.keep = m_tkeep; o.last = m_tlast; o.tid = m_tid; o.cyc = cyc;
      obs_q.push_back(o);
    end
    for (int i = 0; i < NREQ; i++) fire[i] = s_tvalid[i] && s_tready[i] && !areset;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NREQ; i++) begin
      if (fire[i] && src_q[i].size() > 0) begin
        void'(src_q[i].pop_front());
        acc_cnt[i]++;
      end
      if (src_en[i] && src_q[i].size() > 0) begin
        if (!s_tvalid[i]) first_cyc[i] = cyc;
        s_tvalid[i]           = 1'b1;
        s_tdata[i*W +: W]     = src_q[i][0].data;
        s_tkeep[i*KW +: KW]   = src_q[i][0].keep;
        s_tlast[i]            = src_q[i][0].last;
      end else begin
        s_tvalid[i] = 1'b0;
      end
    end
    m_tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic wait_obs(int n, int budget);
    int t = 0;
    while (obs_q.size() < n && t < budget) begin
      tick();
      t++;
    end
  endtask

  task automatic add_pkt(int r, int n, bit idx_data);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = idx_data ? W'(k) : W'($urandom);
      b.keep = KW'($urandom);
      b.last = (k == n - 1);
      src_q[r].push_back(b);
      exp_src[r].push_back(b);
    end
  endtask

  // Reference: whole packets, round robin starting after the last winner.
  task automatic build_expected(int last_winner);
    int   last = last_winner;
    int   r;
    bit   any;
    beat_t b;
    obs_t  e;
    exp_q.delete();
    forever begin
      any = 0;
      for (int k = 1; k <= NREQ && !any; k++) begin
        r = (last + k) % NREQ;
        if (exp_src[r].size() > 0) any = 1;
      end
      if (!any) break;
      do begin
        b = exp_src[r].pop_front();
        e.data = b.data; e.keep = b.keep; e.last = b.last; e.tid = IDW'(r); e.cyc = 0;
        exp_q.push_back(e);
      end while (!b.last && exp_src[r].size() > 0);
      last = r;
    end
  endtask

  task automatic apply_reset();
    areset = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      src_q[i].delete();
      exp_src[i].delete();
      src_en[i]  = 0;
      acc_cnt[i] = 0;
    end
    ctrl_enable = 1'b1;
    bp_mode     = 0;
    tick();
    tick();
    areset = 1'b0;
    tick();
    obs_q.delete();
    stall_viol = 0;
    prev_stall = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got %b want 0", m_tvalid); end
    n_cmp++; if (s_tready !== '0) begin n_fail++; $display("FAIL reset_tready got %b want 00", s_tready); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (stat !== '0) begin n_fail++; $display("FAIL reset_counters got %h want 0", stat); end
    n_cmp++;
    if ({m_tdata, m_tkeep, m_tlast, m_tid} !== '0) begin
      n_fail++; $display("FAIL reset_payload got %h want 0", {m_tdata, m_tkeep, m_tlast, m_tid});
    end
  endtask

  task automatic test_single();
    int want;
    apply_reset();
    for (int p = 0; p < 4; p++) add_pkt(0, 256, 1);
    build_expected(NREQ - 1);
    src_en[0] = 1;
    wait_obs(1024, 3000);
    idle(4);
    n_cmp++; if (obs_q.size() != 1024) begin n_fail++; $display("FAIL single_count got %0d want 1024", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (pack_o(obs_q[i]) !== pack_o(exp_q[i])) begin
        n_fail++; $display("FAIL single_beat[%0d] got %h want %h", i, pack_o(obs_q[i]), pack_o(exp_q[i]));
      end
    end
    for (int i = 1; i < obs_q.size(); i++) begin
      want = obs_q[i-1].last ? 2 : 1;
      n_cmp++;
      if (obs_q[i].cyc - obs_q[i-1].cyc != want) begin
        n_fail++; $display("FAIL single_gap[%0d] got %0d want %0d", i, obs_q[i].cyc - obs_q[i-1].cyc, want);
      end
    end
    n_cmp++; if (cnt(0) != 4) begin n_fail++; $display("FAIL single_cnt0 got %0d want 4", cnt(0)); end
  endtask

  task automatic test_fairness();
    apply_reset();
    for (int p = 0; p < 3; p++) begin
      add_pkt(0, 8, 0);
      add_pkt(1, 8, 0);
    end
    build_expected(NREQ - 1);
    src_en[0] = 1;
    src_en[1] = 1;
    wait_obs(48, 300);
    idle(4);
    n_cmp++; if (obs_q.size() != 48) begin n_fail++; $display("FAIL fair_count got %0d want 48", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (pack_o(obs_q[i]) !== pack_o(exp_q[i])) begin
        n_fail++; $display("FAIL fair_beat[%0d] got %h want %h", i, pack_o(obs_q[i]), pack_o(exp_q[i]));
      end
    end
    n_cmp++; if (cnt(0) != 3) begin n_fail++; $display("FAIL fair_cnt0 got %0d want 3", cnt(0)); end
    n_cmp++; if (cnt(1) != 3) begin n_fail++; $display("FAIL fair_cnt1 got %0d want 3", cnt(1)); end
  endtask

  task automatic test_backpressure();
    int r;
    apply_reset();
    r = int'($urandom_range(0, 1));
    add_pkt(r, 64, 0);
    build_expected(NREQ - 1);
    bp_mode   = 1;
    src_en[r] = 1;
    wait_obs(64, 1500);
    bp_mode = 0;
    idle(8);
    n_cmp++; if (obs_q.size() != 64) begin n_fail++; $display("FAIL bp_count got %0d want 64", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (pack_o(obs_q[i]) !== pack_o(exp_q[i])) begin
        n_fail++; $display("FAIL bp_beat[%0d] got %h want %h", i, pack_o(obs_q[i]), pack_o(exp_q[i]));
      end
    end
    n_cmp++; if (stall_viol != 0) begin n_fail++; $display("FAIL bp_stable got %0d changes want 0", stall_viol); end
  endtask

  task automatic test_enable();
    int   t = 0;
    int   base;
    beat_t b;
    obs_t  e;
    apply_reset();
    add_pkt(1, 16, 0);
    add_pkt(0, 4, 0);
    exp_q.delete();
    for (int r = 1; r >= 0; r--) begin
      while (exp_src[r].size() > 0) begin
        b = exp_src[r].pop_front();
        e.data = b.data; e.keep = b.keep; e.last = b.last; e.tid = IDW'(r); e.cyc = 0;
        exp_q.push_back(e);
      end
    end
    src_en[1] = 1;
    while (!busy && t < 20) begin tick(); t++; end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL en_grant1 got busy=%b want 1", busy); end
    src_en[0] = 1;
    base = acc_cnt[1];
    while (acc_cnt[1] - base < 5 && t < 100) begin tick(); t++; end
    ctrl_enable = 1'b0;
    wait_obs(16, 100);
    idle(20);
    n_cmp++; if (obs_q.size() != 16) begin n_fail++; $display("FAIL en_gated_count got %0d want 16", obs_q.size()); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL en_gated_busy got %b want 0", busy); end
    ctrl_enable = 1'b1;
    wait_obs(20, 100);
    idle(4);
    n_cmp++; if (obs_q.size() != 20) begin n_fail++; $display("FAIL en_count got %0d want 20", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (pack_o(obs_q[i]) !== pack_o(exp_q[i])) begin
        n_fail++; $display("FAIL en_beat[%0d] got %h want %h", i, pack_o(obs_q[i]), pack_o(exp_q[i]));
      end
    end
  endtask

  task automatic test_reset_mid();
    int t = 0;
    int n_out;
    obs_q.delete();
    acc_cnt[0] = 0;
    add_pkt(0, 32, 0);
    src_en[0] = 1;
    while (acc_cnt[0] < 10 && t < 100) begin tick(); t++; end
    areset = 1'b1;
    src_q[0].delete();
    src_en[0] = 0;
    tick();
    n_cmp++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid got %b want 0", m_tvalid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (stat !== '0) begin n_fail++; $display("FAIL rst_counters got %h want 0", stat); end
    tick();
    areset = 1'b0;
    n_out = obs_q.size();
    idle(10);
    n_cmp++; if (obs_q.size() != n_out) begin n_fail++; $display("FAIL rst_truncate got %0d want %0d", obs_q.size(), n_out); end
    obs_q.delete();
    for (int i = 0; i < NREQ; i++) exp_src[i].delete();
    add_pkt(1, 4, 0);
    build_expected(NREQ - 1);
    src_en[1] = 1;
    wait_obs(4, 50);
    idle(3);
    n_cmp++; if (obs_q.size() != 4) begin n_fail++; $display("FAIL rst_next_count got %0d want 4", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (pack_o(obs_q[i]) !== pack_o(exp_q[i])) begin
        n_fail++; $display("FAIL rst_next_beat[%0d] got %h want %h", i, pack_o(obs_q[i]), pack_o(exp_q[i]));
      end
    end
    if (obs_q.size() > 0) begin
      n_cmp++;
      if (obs_q[0].cyc - first_cyc[1] != 2) begin
        n_fail++; $display("FAIL rst_latency got %0d want 2", obs_q[0].cyc - first_cyc[1]);
      end
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int p = 0; p < 17; p++) add_pkt(0, 1, 0);
    src_en[0] = 1;
    wait_obs(17, 300);
    idle(4);
    n_cmp++; if (obs_q.size() != 17) begin n_fail++; $display("FAIL wrap_count got %0d want 17", obs_q.size()); end
    n_cmp++; if (cnt(0) != 1) begin n_fail++; $display("FAIL wrap_cnt0 got %0d want 1", cnt(0)); end
    n_cmp++; if (cnt(1) != 0) begin n_fail++; $display("FAIL wrap_cnt1 got %0d want 0", cnt(1)); end
  endtask

  initial begin
    s_tvalid = '0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = '0;
    m_tready = 1'b1;
    cyc = 0; n_cmp = 0; n_fail = 0; stall_viol = 0; prev_stall = 0; prev_pl = '0; bp_mode = 0;
    for (int i = 0; i < NREQ; i++) begin
      src_en[i] = 0; acc_cnt[i] = 0; first_cyc[i] = 0;
    end
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_enable();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/myadder1_stream_arbiter.md
# myadder1_stream_arbiter

Packet-granular round-robin arbiter that shares a single vadd AXI4-Stream datapath between `C_NUM_REQ` host input streams. It sits between the kernel's input pipes and the adder's `s_axis` port. It holds a grant from the first beat to `tlast` of a packet, tags each output beat with the requester index, and keeps per-requester completed-packet counters.

## Interface
Parameters:
- `C_NUM_REQ`, 2: number of requesters; legal range 2..4.
- `C_TDATA_WIDTH`, 512: tdata width of every stream; multiple of 8.
- `C_CNT_WIDTH`, 32: width of each packet counter.

Ports:
- `ap_clk`, in, 1: the only clock; all logic is on the rising edge.
- `areset`, in, 1: synchronous, active-high reset.
- `ctrl_enable`, in, 1: when 1, new grants are allowed.
- `s_axis_tvalid`, in, `C_NUM_REQ`: per-requester valid.
- `s_axis_tready`, out, `C_NUM_REQ`: per-requester ready.
- `s_axis_tdata`, in, `C_NUM_REQ*C_TDATA_WIDTH`: packed; requester i occupies slice i.
- `s_axis_tkeep`, in, `C_NUM_REQ*C_TDATA_WIDTH/8`: packed keep.
- `s_axis_tlast`, in, `C_NUM_REQ`: per-requester last.
- `m_axis_tvalid` / `m_axis_tready` / `m_axis_tdata` / `m_axis_tkeep` / `m_axis_tlast`: out/in/out/out/out, with widths 1 / 1 / `C_TDATA_WIDTH` / `C_TDATA_WIDTH/8` / 1. These drive the adder input.
- `m_axis_tid`, out, `IDW = max(1,$clog2(C_NUM_REQ))`: index of the granted requester.
- `busy`, out, 1: 1 while in state LOCKED.
- `stat_pkt_count`, out, `C_NUM_REQ*C_CNT_WIDTH`: packed completed-packet counters.

## Operation
- The FSM has two states, IDLE and LOCKED.
- **IDLE:**
  - All `s_axis_tready` are 0.
  - If `ctrl_enable` is 1 and any `s_axis_tvalid` is 1, pick the first valid requester, searching from `last_grant+1` modulo `C_NUM_REQ` upward.
  - Register the pick into `grant` and go to LOCKED.
- **LOCKED:**
  - `s_axis_tready[grant]` equals the skid buffer's input ready; all other readies are 0.
  - The selected beat and `grant` as tid are written into the skid buffer.
  - When a beat with `tlast=1` is accepted: set `last_grant <= grant`, increment `stat_pkt_count[grant]`, and go to IDLE.
- **`ctrl_enable` deasserted:** only gates IDLE→LOCKED. A packet in progress always completes.
- **Counters:** wrap modulo 2^`C_CNT_WIDTH` with no saturation. They are cleared only by `areset`.
- **Output stage:** a two-entry skid buffer.
  - Sustains 1 beat/cycle under continuous `m_axis_tready`.
  - `m_axis_*` payload is stable while `m_axis_tvalid=1` and `m_axis_tready=0`.
- **tkeep:** passed through unmodified. Sparse keep is not checked.
- **Reset:**
  - FSM returns to IDLE and `last_grant` is set to `C_NUM_REQ-1`, so requester 0 wins first.
  - Counters go to 0 and the skid buffer is emptied.
  - Reset mid-packet truncates the packet: the remaining beats are never emitted, and no recovery is made.

## Timing
- **Reset values:**
  - `m_axis_tvalid` = 0, `s_axis_tready` = all 0, `busy` = 0, `stat_pkt_count` = 0.
  - `m_axis_tdata`, `m_axis_tkeep`, `m_axis_tlast`, `m_axis_tid` = 0.
- **Latency:** valid in IDLE at cycle N gives LOCKED and tready at N+1; the beat is accepted at N+1 and `m_axis_tvalid` rises at N+2.
- **Inter-packet gap:** exactly one arbitration cycle (the IDLE cycle) between the `tlast` acceptance and the next packet's first tready.
- **Simultaneous events:**
  - `tlast` accepted in the same cycle that other requesters are valid: the next grant is evaluated in the following IDLE cycle against the updated `last_grant`.
  - A counter increment and an `areset` in the same cycle: reset wins.
- **Requester handshake:** a requester may drop `tvalid` mid-packet (an AXI violation). The arbiter stays LOCKED and waits; it does not time out.

## Structure
- Package `myadder1_arb_pkg`:
  - typedef `arb_state_t` enum {IDLE, LOCKED};
  - localparam `LP_MAX_REQ = 4`;
  - function `f_idw(n)` returning max(1,$clog2(n)).
- Sub-module `myadder1_axis_skid`: parameterised payload width of tdata+tkeep+tlast+tid; carries the two-entry skid with registered ready.
- Round-robin pick: a combinational rotate-and-priority function in the main module.

## Test plan
- **Single requester:** requester 0 sends 4 packets of 256 beats with tdata = beat index and `m_axis_tready` held at 1.
  - Required: 1024 beats out in order; tid = 0; `stat_pkt_count[0]` = 4; exactly 1 idle cycle between packets.
- **Fairness:** both requesters continuously valid, 3 packets each of 8 beats.
  - Required: output tid sequence 0,1,0,1,0,1; no interleaving inside a packet; both counters = 3.
- **Backpressure:** `m_axis_tready` randomly 50% during a 64-beat packet.
  - Required: no lost or duplicated beats; payload stable while stalled; `tlast` on beat 63 only.
- **Enable gating:** `ctrl_enable` drops at beat 5 of a 16-beat packet from requester 1, while requester 0 is valid.
  - Required: all 16 beats complete; no new grant until `ctrl_enable` is 1 again; then requester 0 is granted.
- **Reset mid-packet:** `areset` pulses at beat 10 of a 32-beat packet.
  - Required: the next cycle has `m_axis_tvalid` = 0, all counters = 0 and `busy` = 0; the next packet from requester 1 alone gets tid = 1 with 2-cycle latency.
- **Counter wrap:** `C_CNT_WIDTH = 4`, 17 single-beat packets from requester 0.
  - Required: `stat_pkt_count[0]` = 1.
